// File: rtl/game_pkg.sv
// Shared encodings for the game flow controller: FSM state codes, Event bit
// positions, timer constants and small score helpers.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PLAY   = 3'd1,
      ST_PAUSED = 3'd2,
      ST_DYING  = 3'd3,
      ST_OVER   = 3'd4,
      ST_WIN    = 3'd5
   } state_t;

   localparam int EV_HIT      = 0;
   localparam int EV_KILL_LSB = 1;
   localparam int EV_KILL_MSB = 3;

   localparam int TICKS_PER_SEC = 24;
   localparam int TICK_W        = $clog2(TICKS_PER_SEC);
   localparam int GAME_SECONDS  = 60;

   // Number of dragons killed in one cycle (0..3).
   function automatic logic [1:0] kill_count(input logic [2:0] k);
      return {1'b0, k[0]} + {1'b0, k[1]} + {1'b0, k[2]};
   endfunction

   function automatic logic [3:0] score_add(input logic [3:0] s, input logic [1:0] n);
      logic [4:0] sum;
      sum = {1'b0, s} + {3'b000, n};
      return sum[4] ? 4'hF : sum[3:0];
   endfunction

endpackage

// File: rtl/edge_det.sv
// One-bit rising-edge detector: one registered copy of the input, pulse on 0->1.
module edge_det (
   input  logic clk_22,
   input  logic rst,
   input  logic i_d,
   output logic o_rise
);

   logic r_prev;

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk_22 or negedge rst) begin
      if (!rst) r_prev <= 1'b0;
      else      r_prev <= i_d;
   end

   assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow FSM: lives, score, pause and respawn sequencing for the robot game.
// Optional countdown timer enabled by defining GAME_TIMER_EN.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int LIVES_INIT  = 3,
   parameter int RESPAWN_CYC = 100,
   parameter int WIN_SCORE   = 3
) (
   input  logic       clk_22,
   input  logic       rst,
   input  logic       start_key,
   input  logic       pause_key,
   input  logic [3:0] Event,
   output logic       pause,
   output logic       respawn,
   output logic [2:0] lives,
   output logic [3:0] score,
   output logic [2:0] state,
   output logic [7:0] time_left
);

   localparam int            CW        = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;
   localparam logic [CW-1:0] COOL_LAST = CW'(RESPAWN_CYC - 1);
   localparam logic [2:0]    LIVES_Q   = 3'(LIVES_INIT);
   localparam logic [3:0]    WIN_Q     = 4'(WIN_SCORE);

   logic          w_start;
   logic          w_pause_edge;
   logic [2:0]    w_kill_rise;
   logic          w_start_go;
   logic          w_timeout;

   state_t        r_state;
   state_t        r_ret;
   logic          r_pause;
   logic          r_respawn;
   logic [2:0]    r_lives;
   logic [3:0]    r_score;
   logic [CW-1:0] r_cool;
   logic [2:0]    r_kill_prev;

   edge_det u_start_edge (
      .clk_22 (clk_22),
      .rst    (rst),
      .i_d    (start_key),
      .o_rise (w_start)
   );

   edge_det u_pause_edge (
      .clk_22 (clk_22),
      .rst    (rst),
      .i_d    (pause_key),
      .o_rise (w_pause_edge)
   );

   assign w_kill_rise = Event[EV_KILL_MSB:EV_KILL_LSB] & ~r_kill_prev;
   assign w_start_go  = w_start &&
                        (r_state == ST_IDLE || r_state == ST_OVER || r_state == ST_WIN);

`ifdef GAME_TIMER_EN
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

   logic [TICK_W-1:0] r_tick;
   logic [7:0]        r_time;
   logic              w_running;

   assign w_running = (r_state == ST_PLAY || r_state == ST_DYING) && (r_time != 8'd0);

   always_ff @(posedge clk_22 or negedge rst) begin
      if (!rst) begin
         r_tick <= '0;
         r_time <= 8'd0;
      end else if (w_start_go) begin
         r_tick <= '0;
         r_time <= 8'(GAME_SECONDS);
      end else if (w_running) begin
         if (r_tick == TICK_LAST) begin
            r_tick <= '0;
            r_time <= r_time - 8'd1;
         end else begin
            r_tick <= r_tick + 1'b1;
         end
      end
   end

   // Timeout fires on the same edge that the last second expires.
   assign w_timeout = w_running && (r_tick == TICK_LAST) && (r_time == 8'd1);
   assign time_left = r_time;
`else
   assign w_timeout = 1'b0;
   assign time_left = 8'd0;
`endif

   always_ff @(posedge clk_22 or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_ret       <= ST_PLAY;
         r_pause     <= 1'b1;
         r_respawn   <= 1'b0;
         r_lives     <= LIVES_Q;
         r_score     <= 4'd0;
         r_cool      <= '0;
         r_kill_prev <= 3'b000;
      end else begin
         r_respawn   <= 1'b0;
         r_kill_prev <= Event[EV_KILL_MSB:EV_KILL_LSB];
         case (r_state)
            ST_IDLE, ST_OVER, ST_WIN: begin
               if (w_start) begin
                  r_lives <= LIVES_Q;
                  r_score <= 4'd0;
                  r_cool  <= '0;
                  r_state <= ST_PLAY;
                  r_pause <= 1'b0;
               end
            end
            ST_PLAY: begin
               if (r_score >= WIN_Q) begin
                  r_state <= ST_WIN;
                  r_pause <= 1'b1;
               end else if (w_timeout) begin
                  r_state <= ST_OVER;
                  r_pause <= 1'b1;
               end else if (w_pause_edge) begin
                  r_ret   <= ST_PLAY;
                  r_state <= ST_PAUSED;
                  r_pause <= 1'b1;
               end else begin
                  r_score <= score_add(r_score, kill_count(w_kill_rise));
                  if (Event[EV_HIT]) begin
                     if (r_lives != 3'd0) r_lives <= r_lives - 3'd1;
                     r_cool  <= '0;
                     r_state <= ST_DYING;
                  end
               end
            end
            ST_DYING: begin
               if (r_score >= WIN_Q) begin
                  r_state <= ST_WIN;
                  r_pause <= 1'b1;
               end else if (w_timeout) begin
                  r_state <= ST_OVER;
                  r_pause <= 1'b1;
               end else if (w_pause_edge) begin
                  r_ret   <= ST_DYING;
                  r_state <= ST_PAUSED;
                  r_pause <= 1'b1;
               end else if (r_cool == COOL_LAST) begin
                  r_cool <= '0;
                  if (r_lives == 3'd0) begin
                     r_state <= ST_OVER;
                     r_pause <= 1'b1;
                  end else begin
                     r_state   <= ST_PLAY;
                     r_respawn <= 1'b1;
                  end
               end else begin
                  r_cool <= r_cool + 1'b1;
               end
            end
            ST_PAUSED: begin
               // Cooldown, lives and score are untouched here, so resuming continues exactly.
               if (w_pause_edge) begin
                  r_state <= r_ret;
                  r_pause <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_pause <= 1'b1;
            end
         endcase
      end
   end

   assign pause   = r_pause;
   assign respawn = r_respawn;
   assign lives   = r_lives;
   assign score   = r_score;
   assign state   = r_state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural game model.
module tb_game_flow_ctrl;

   localparam int LIVES = 3;
   localparam int RESP  = 100;
   localparam int WIN   = 3;

   logic       clk_22 = 1'b0;
   logic       rst = 1'b0;
   logic       start_key = 1'b0;
   logic       pause_key = 1'b0;
   logic [3:0] Event = 4'd0;
   logic       pause;
   logic       respawn;
   logic [2:0] lives;
   logic [3:0] score;
   logic [2:0] state;
   logic [7:0] time_left;

   always #5 clk_22 = ~clk_22;

   game_flow_ctrl #(
      .LIVES_INIT  (LIVES),
      .RESPAWN_CYC (RESP),
      .WIN_SCORE   (WIN)
   ) dut (
      .clk_22    (clk_22),
      .rst       (rst),
      .start_key (start_key),
      .pause_key (pause_key),
      .Event     (Event),
      .pause     (pause),
      .respawn   (respawn),
      .lives     (lives),
      .score     (score),
      .state     (state),
      .time_left (time_left)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: game phase plus "cycles of dying left" and
   // "cycles until next second" countdowns.
   int       m_state, m_resume, m_lives, m_score, m_dying_left, m_sec, m_ticks;
   bit       m_respawn, m_prev_start, m_prev_pause;
   bit [2:0] m_prev_kill;

   function automatic void model_reset();
      m_state = 0; m_resume = 1; m_lives = LIVES; m_score = 0;
      m_dying_left = 0; m_sec = 0; m_ticks = 24; m_respawn = 0;
      m_prev_start = 0; m_prev_pause = 0; m_prev_kill = 3'b000;
   endfunction

   function automatic void model_step(bit s, bit p, bit [3:0] ev);
      bit       st_e, pa_e, timeout;
      bit [2:0] rise;
      st_e = s && !m_prev_start;
      pa_e = p && !m_prev_pause;
      rise = ev[3:1] & ~m_prev_kill;
      m_prev_start = s; m_prev_pause = p; m_prev_kill = ev[3:1];
      m_respawn = 0;
      timeout = 0;
`ifdef GAME_TIMER_EN
      if ((m_state == 1 || m_state == 3) && m_sec > 0) begin
         m_ticks--;
         if (m_ticks == 0) begin
            m_ticks = 24;
            m_sec--;
            timeout = (m_sec == 0);
         end
      end
`endif
      case (m_state)
         0, 4, 5: if (st_e) begin
            m_lives = LIVES; m_score = 0; m_state = 1;
`ifdef GAME_TIMER_EN
            m_sec = 60; m_ticks = 24;
`endif
         end
         1: begin
            if (m_score >= WIN) m_state = 5;
            else if (timeout) m_state = 4;
            else if (pa_e) begin m_resume = 1; m_state = 2; end
            else begin
               m_score = m_score + $countones(rise);
               if (m_score > 15) m_score = 15;
               if (ev[0]) begin
                  if (m_lives > 0) m_lives--;
                  m_dying_left = RESP;
                  m_state = 3;
               end
            end
         end
         3: begin
            if (m_score >= WIN) m_state = 5;
            else if (timeout) m_state = 4;
            else if (pa_e) begin m_resume = 3; m_state = 2; end
            else begin
               m_dying_left--;
               if (m_dying_left == 0) begin
                  if (m_lives == 0) m_state = 4;
                  else begin m_state = 1; m_respawn = 1; end
               end
            end
         end
         2: if (pa_e) m_state = m_resume;
         default: ;
      endcase
   endfunction

   task automatic compare_all();
      bit exp_pause;
      exp_pause = (m_state == 0 || m_state == 2 || m_state == 4 || m_state == 5);
      check("state", state, m_state);
      check("pause", pause, exp_pause);
      check("respawn", respawn, m_respawn);
      check("lives", lives, m_lives);
      check("score", score, m_score);
      check("time_left", time_left, m_sec);
   endtask

   // Called at a negedge: drive, clock once, update model, compare at next negedge.
   task automatic tick(input bit s, input bit p, input bit [3:0] ev);
      start_key = s; pause_key = p; Event = ev;
      @(posedge clk_22);
      model_step(s, p, ev);
      @(negedge clk_22);
      compare_all();
   endtask

   task automatic wait_respawn(input int max_cyc, output int lat);
      lat = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         tick(1'b0, 1'b0, 4'd0);
         if (respawn === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, pulses;
      model_reset();
      @(negedge clk_22);
      @(negedge clk_22);
      check("rst_state", state, 0);
      check("rst_pause", pause, 1);
      check("rst_respawn", respawn, 0);
      check("rst_lives", lives, 3);
      check("rst_score", score, 0);
      check("rst_time", time_left, 0);
      rst = 1'b1;

      // Start a game.
      tick(0, 0, 4'd0);
      tick(1, 0, 4'd0);
      check("start_state", state, 1);
      check("start_lives", lives, 3);
      check("start_score", score, 0);
      check("start_pause", pause, 0);

      // Single hit and respawn latency.
      tick(0, 0, 4'b0001);
      check("hit_lives", lives, 2);
      check("hit_state", state, 3);
      wait_respawn(200, lat);
      check("respawn_lat", lat, 100);
      check("respawn_state", state, 1);
      tick(0, 0, 4'd0);
      check("respawn_one_cycle", respawn, 0);

      // Pause mid-cooldown at count 40, long hold with ignored events.
      tick(0, 0, 4'b0001);
      repeat (40) tick(0, 0, 4'd0);
      tick(0, 1, 4'd0);
      check("dying_paused", state, 2);
      for (int i = 0; i < 500; i++) tick(0, 0, 4'($urandom_range(0, 15)));
      check("hold_state", state, 2);
      check("hold_lives", lives, 1);
      check("hold_score", score, 0);
      tick(0, 1, 4'd0);
      check("resume_state", state, 3);
      wait_respawn(200, lat);
      check("resume_lat", lat, 60);

      // Triple kill, then WIN beats a same-cycle hit.
      tick(0, 0, 4'b1110);
      check("triple_score", score, 3);
      check("triple_state", state, 1);
      tick(0, 0, 4'b1111);
      check("win_state", state, 5);
      check("win_pause", pause, 1);
      check("win_lives", lives, 1);

      // Start+pause together: start wins in WIN, pause wins in PLAY.
      tick(1, 1, 4'd0);
      check("win_restart", state, 1);
      check("win_restart_lives", lives, 3);
      tick(0, 0, 4'd0);
      tick(1, 1, 4'd0);
      check("play_both_edges", state, 2);
      tick(0, 0, 4'd0);
      tick(0, 1, 4'd0);
      check("unpause_play", state, 1);
      tick(0, 0, 4'd0);

      // Three hits: game over without a respawn pulse.
      for (int h = 0; h < 3; h++) begin
         tick(0, 0, 4'b0001);
         if (h < 2) begin
            wait_respawn(200, lat);
            check("multi_resp_lat", lat, 100);
         end
      end
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         tick(0, 0, 4'd0);
         if (respawn === 1'b1) pulses++;
      end
      check("over_state", state, 4);
      check("over_no_respawn", pulses, 0);
      check("over_lives", lives, 0);
      tick(1, 0, 4'd0);
      check("over_restart_lives", lives, 3);
      check("over_restart_state", state, 1);
      tick(0, 0, 4'd0);

      // Asynchronous reset in the middle of a cooldown.
      tick(0, 0, 4'b0001);
      repeat (30) tick(0, 0, 4'd0);
      #2 rst = 1'b0;
      #1;
      check("arst_state", state, 0);
      check("arst_respawn", respawn, 0);
      check("arst_lives", lives, 3);
      check("arst_pause", pause, 1);
      model_reset();
      @(negedge clk_22);
      rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 150; i++) begin
         tick(0, 0, 4'd0);
         if (respawn === 1'b1) pulses++;
      end
      check("arst_no_respawn", pulses, 0);

      // Randomized play against the model.
      for (int i = 0; i < 3000; i++) begin
         bit       s, p;
         bit [3:0] ev;
         s = ($urandom_range(0, 15) == 0);
         p = ($urandom_range(0, 19) == 0);
         ev[0] = ($urandom_range(0, 39) == 0);
         for (int b = 1; b < 4; b++) ev[b] = ($urandom_range(0, 29) == 0);
         tick(s, p, ev);
      end

`ifdef GAME_TIMER_EN
      // Full-length game timeout.
      @(negedge clk_22);
      rst = 1'b0;
      model_reset();
      @(negedge clk_22);
      rst = 1'b1;
      tick(1, 0, 4'd0);
      check("timer_load", time_left, 60);
      repeat (1440) tick(0, 0, 4'd0);
      check("timer_zero", time_left, 0);
      check("timer_over", state, 4);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3, robot lives granted at game start (range 1..7).
REQ-002 Parameter RESPAWN_CYC, default 100, clk_22 cycles spent in DYING before respawn.
REQ-003 Parameter WIN_SCORE, default 3, dragon kills needed to win (range 1..15).
REQ-004 clk_22  input  1  game tick clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start_key  input  1  level from keyboard decoder; rising edge starts or restarts a game.
REQ-007 pause_key  input  1  level from keyboard decoder; rising edge toggles pause.
REQ-008 Event  input  4  bit0 robot hit, bits3:1 dragon 1..3 killed; level, sampled each cycle.
REQ-009 pause  output  1  freeze command to robot and dragon movers.
REQ-010 respawn  output  1  one-cycle pulse ordering the robot back to its start position.
REQ-011 lives  output  3  remaining lives.
REQ-012 score  output  4  dragon kills this game.
REQ-013 state  output  3  FSM state code: IDLE=0, PLAY=1, PAUSED=2, DYING=3, OVER=4, WIN=5.
REQ-014 time_left  output  8  remaining game seconds (see Configuration).

Function
REQ-015 The block SHALL edge-detect start_key and pause_key with one registered copy each; only 0->1 transitions act.
REQ-016 IDLE: pause=1; a start edge SHALL load lives=LIVES_INIT and score=0, then enter PLAY.
REQ-017 PLAY: pause=0; a pause edge SHALL enter PAUSED; Event[0]=1 SHALL decrement lives and enter DYING.
REQ-018 PLAY: each Event[3:1] bit SHALL be counted once per rising edge of that bit; simultaneous kills SHALL add the number of rising bits (0..3) in one cycle; score SHALL saturate at 15.
REQ-019 When score reaches or exceeds WIN_SCORE, the FSM SHALL enter WIN on the next cycle; WIN takes priority over a same-cycle Event[0].
REQ-020 PAUSED: pause=1; all counters SHALL hold; Event SHALL be ignored; a pause edge SHALL return to the state that was paused (PLAY or DYING).
REQ-021 DYING: pause=0; a cooldown counter SHALL count RESPAWN_CYC cycles, then pulse respawn for exactly one cycle and enter PLAY; if lives reached 0 on entry, the FSM SHALL enter OVER instead, with no respawn pulse.
REQ-022 DYING: Event[0] SHALL be ignored; a pause edge SHALL enter PAUSED with the cooldown count frozen.
REQ-023 OVER and WIN: pause=1; a start edge SHALL behave as in IDLE.
REQ-024 A start edge in PLAY, PAUSED or DYING SHALL be ignored.
REQ-025 A pause edge and a start edge in the same cycle: the start edge SHALL take priority in IDLE, OVER and WIN; the pause edge SHALL take priority elsewhere.
REQ-026 lives SHALL never underflow below 0.

Reset
REQ-027 When rst=0, the block SHALL force state=IDLE, pause=1, respawn=0, lives=LIVES_INIT, score=0, time_left=0, zero the cooldown counter, and clear the edge registers, asynchronously.
REQ-028 Reset SHALL take effect in any state, mid-cooldown included, with no respawn pulse generated.

Configuration
REQ-029 With GAME_TIMER_EN defined, a start edge SHALL load time_left=60; time_left SHALL decrement every TICKS_PER_SEC clk_22 cycles (package constant, 24) while in PLAY or DYING; reaching 0 SHALL enter OVER (priority below WIN).
REQ-030 Without GAME_TIMER_EN, time_left SHALL be tied to 0 and no timeout exists.

Structure
REQ-031 State encodings, TICKS_PER_SEC and the Event bit indices SHALL live in package game_pkg.
REQ-032 The sub-module edge_det (one-bit rising-edge detector, async active-low reset) SHALL be instantiated for start_key and pause_key.

Verification
REQ-033 Reset, start edge -> state=1, lives=3, score=0, pause=0.
REQ-034 In PLAY, Event[0] for 1 cycle -> lives=2, state=3; exactly 100 cycles later respawn=1 for one cycle, state=1.
REQ-035 Event[3:1]=3'b111 in one cycle -> score=3, next cycle state=5, pause=1.
REQ-036 Pause edge during DYING at cooldown count 40, hold 500 cycles, pause edge -> respawn occurs 60 cycles after resume.
REQ-037 Three hits with lives=3 -> after the third cooldown, state=4, no respawn pulse; start edge -> lives=3, state=1.
REQ-038 GAME_TIMER_EN defined: start edge, 1440 PLAY cycles -> time_left=0, state=4.
